mul_table_writer: RTL and testbench

- Sequential generator that fills a multiplication-table memory. It walks every operand pair {a,b}, computes a*b with a shift-add multiplier and issues one write per entry on a simple valid/ready write port.
- It is the writer for the table memory, which is addressed as {a,b} with the product as data.
- It sits in front of a RAM-backed table so the table contents are computed in hardware, not preloaded.

---
 rtl/mul_table_pkg.sv | 19 +
 rtl/mul_table_writer_shift_add_mul.sv | 57 +++++
 rtl/mul_table_writer.sv | 100 ++++++++++
 tb/tb_mul_table_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_table_pkg.sv
// Shared types and defaults for the multiplication-table writer and its multiplier.
package mul_table_pkg;

    localparam int unsigned DEF_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bit-counter width able to count 0..w-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mul_table_writer_shift_add_mul.sv
// Sequential unsigned shift-add multiplier: loads on go, then takes exactly W step cycles.
module shift_add_mul
    import mul_table_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             rdy,
    output logic [2*W-1:0]   product
);

    localparam int unsigned      P_W      = 2 * W;
    localparam int unsigned      CNT_W    = cnt_width(W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    logic [P_W-1:0]   mcand;
    logic [P_W-1:0]   acc;
    logic [W-1:0]     mplier;
    logic [CNT_W-1:0] bitcnt;
    logic             active;

    // One multiplier bit per cycle; the last step is flagged by rdy while it happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            bitcnt <= '0;
            active <= 1'b0;
        end else if (go) begin
            mcand  <= P_W'(a);
            acc    <= '0;
            mplier <= b;
            bitcnt <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (bitcnt == LAST_BIT) begin
                active <= 1'b0;
            end else begin
                bitcnt <= bitcnt + CNT_W'(1);
            end
        end
    end

    assign rdy     = active && (bitcnt == LAST_BIT);
    assign product = acc;

endmodule

// File: rtl/mul_table_writer.sv
// Walks every {a,b} operand pair, multiplies with shift_add_mul and writes a*b at address {a,b}.
module mul_table_writer
    import mul_table_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              we,
    input  logic              wr_ready,
    output logic [2*W-1:0]    addr,
    output logic [2*W-1:0]    wdata
);

    localparam int unsigned       ADDR_W     = 2 * W;
    localparam logic [ADDR_W-1:0] LAST_INDEX = '1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] index;
    logic              mul_go;
    logic              mul_rdy;
    logic [ADDR_W-1:0] product;

    shift_add_mul #(
        .W(W)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .go     (mul_go),
        .a      (index[ADDR_W-1:W]),
        .b      (index[W-1:0]),
        .rdy    (mul_rdy),
        .product(product)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = MUL;
            MUL:     if (mul_rdy) state_next = WRITE;
            WRITE: begin
                if (wr_ready) begin
                    state_next = (index == LAST_INDEX) ? DONE : LOAD;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Entry index only advances on an accepted write; it returns to zero through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            index <= '0;
        end else if (state == DONE || (state == IDLE && start)) begin
            index <= '0;
        end else if (state == WRITE && wr_ready && index != LAST_INDEX) begin
            index <= index + ADDR_W'(1);
        end
    end

    // Outputs decoded from registered state only; addr/wdata are stable while WRITE stalls.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        we     = 1'b0;
        mul_go = 1'b0;
        addr   = index;
        wdata  = product;
        case (state)
            LOAD: begin
                busy   = 1'b1;
                mul_go = 1'b1;
            end
            MUL:     busy = 1'b1;
            WRITE: begin
                busy = 1'b1;
                we   = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_table_writer.sv
// Self-checking bench for mul_table_writer (W=4 and W=3) against a timeline/arithmetic reference model.
module tb_mul_table_writer;

    localparam int MAXC = 4000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic       clk;
    logic       reset4, start4, wr_ready4, busy4, done4, we4;
    logic [7:0] addr4, wdata4;
    logic       reset3, start3, wr_ready3, busy3, done3, we3;
    logic [5:0] addr3, wdata3;

    int  cyc;
    int  n_checks;
    int  n_pass;
    int  n_fail;
    bit  sel3;
    bit  rdy_a [MAXC];
    bit  st_a  [MAXC];
    bit  rs_a  [MAXC];
    wr_t acc4[$], pres4[$], done4_q[$];
    wr_t acc3[$], done3_q[$];
    wr_t exp_q[$];
    int  exp_done;

    mul_table_writer #(.W(4)) dut4 (
        .clk(clk), .reset(reset4), .start(start4), .busy(busy4), .done(done4),
        .we(we4), .wr_ready(wr_ready4), .addr(addr4), .wdata(wdata4)
    );

    mul_table_writer #(.W(3)) dut3 (
        .clk(clk), .reset(reset3), .start(start3), .busy(busy3), .done(done3),
        .we(we3), .wr_ready(wr_ready3), .addr(addr3), .wdata(wdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/done logger, sampled mid-cycle; a write is accepted at the next rising edge.
    always @(negedge clk) begin
        if (we4 === 1'b1) begin
            pres4.push_back('{32'(addr4), 32'(wdata4), cyc});
            if (wr_ready4) acc4.push_back('{32'(addr4), 32'(wdata4), cyc});
        end
        if (done4 === 1'b1) done4_q.push_back('{32'd0, 32'(busy4), cyc});
        if (we3 === 1'b1 && wr_ready3) acc3.push_back('{32'(addr3), 32'(wdata3), cyc});
        if (done3 === 1'b1) done3_q.push_back('{32'd0, 32'(busy3), cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            rdy_a[i] = 1'b1;
            st_a[i]  = 1'b0;
            rs_a[i]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset4 = 1'b1; reset3 = 1'b1;
        start4 = 1'b0; start3 = 1'b0;
        wr_ready4 = 1'b1; wr_ready3 = 1'b1;
        step();
        reset4 = 1'b0; reset3 = 1'b0;
        acc4.delete(); pres4.delete(); done4_q.delete();
        acc3.delete(); done3_q.delete();
        cyc = 0;
    endtask

    // Applies the per-cycle stimulus tables to the selected DUT until cycle tgt.
    task automatic run_until(input int tgt);
        while (cyc < tgt && cyc < MAXC) begin
            if (sel3) begin
                start3 = st_a[cyc]; wr_ready3 = rdy_a[cyc]; reset3 = rs_a[cyc];
                start4 = 1'b0; wr_ready4 = 1'b1; reset4 = 1'b0;
            end else begin
                start4 = st_a[cyc]; wr_ready4 = rdy_a[cyc]; reset4 = rs_a[cyc];
                start3 = 1'b0; wr_ready3 = 1'b1; reset3 = 1'b0;
            end
            step();
        end
    endtask

    // Reference: each entry needs W+2 cycles after the previous acceptance, then waits for ready.
    function automatic void model_fill(input int w, input int t0);
        int t;
        t = t0;
        exp_q.delete();
        for (int n = 0; n < (1 << (2 * w)); n++) begin
            t += w + 2;
            while (!rdy_a[t] && t < MAXC - 10) t++;
            exp_q.push_back('{32'(n), 32'((n >> w) * (n & ((1 << w) - 1))), t});
        end
        exp_done = t + 1;
    endfunction

    task automatic cmp_writes(input string tag, input wr_t act[$]);
        for (int k = 0; k < exp_q.size() && k < act.size(); k++) begin
            chk($sformatf("%s_addr[%0d]", tag, k), act[k].addr, exp_q[k].addr);
            chk($sformatf("%s_data[%0d]", tag, k), act[k].data, exp_q[k].data);
            chk($sformatf("%s_cyc[%0d]", tag, k), 32'(act[k].cyc), 32'(exp_q[k].cyc));
        end
    endtask

    initial begin
        int cnt;
        int t0;
        n_checks = 0; n_pass = 0; n_fail = 0;
        cyc = 0; sel3 = 1'b0;
        clear_stim();

        // Reset state
        do_reset();
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_we", 32'(we4), 32'd0);
        chk("rst_addr", 32'(addr4), 32'd0);
        chk("rst_wdata", 32'(wdata4), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);

        // Full fill with ignored start pulses mid-fill and in DONE, then a restart
        clear_stim();
        st_a[0] = 1'b1; st_a[100] = 1'b1; st_a[1537] = 1'b1; st_a[1539] = 1'b1;
        do_reset();
        model_fill(4, 0);
        run_until(1);
        chk("c1_busy", 32'(busy4), 32'd1);
        chk("c1_we", 32'(we4), 32'd0);
        run_until(6);
        chk("c6_we", 32'(we4), 32'd1);
        chk("c6_addr", 32'(addr4), 32'd0);
        run_until(1550);
        chk("fill_count", 32'(acc4.size()), 32'd257);
        cmp_writes("fill", acc4);
        if (acc4.size() == 257) begin
            chk("w35_cyc", 32'(acc4[8'h35].cyc), 32'd324);
            chk("w35_data", acc4[8'h35].data, 32'h0F);
            chk("wFF_data", acc4[8'hFF].data, 32'hE1);
            chk("w0F_data", acc4[8'h0F].data, 32'h00);
            chk("w10_data", acc4[8'h10].data, 32'h00);
            chk("w11_data", acc4[8'h11].data, 32'h01);
            chk("refill_addr", acc4[256].addr, 32'd0);
            chk("refill_cyc", 32'(acc4[256].cyc), 32'd1545);
        end
        chk("done_count", 32'(done4_q.size()), 32'd1);
        if (done4_q.size() > 0) begin
            chk("done_cyc", 32'(done4_q[0].cyc), 32'd1537);
            chk("done_busy", done4_q[0].data, 32'd0);
        end

        // Backpressure on address 0x12
        clear_stim();
        st_a[0] = 1'b1;
        rdy_a[114] = 1'b0; rdy_a[115] = 1'b0; rdy_a[116] = 1'b0;
        do_reset();
        model_fill(4, 0);
        run_until(1545);
        chk("bp_count", 32'(acc4.size()), 32'd256);
        cmp_writes("bp", acc4);
        cnt = 0;
        foreach (pres4[i]) begin
            if (pres4[i].addr == 32'h12) begin
                chk($sformatf("bp_hold_data[%0d]", cnt), pres4[i].data, 32'h02);
                chk($sformatf("bp_hold_cyc[%0d]", cnt), 32'(pres4[i].cyc), 32'(114 + cnt));
                cnt++;
            end
        end
        chk("bp_hold_len", 32'(cnt), 32'd4);
        chk("bp_done_count", 32'(done4_q.size()), 32'd1);
        if (done4_q.size() > 0) chk("bp_done_cyc", 32'(done4_q[0].cyc), 32'd1540);

        // Random backpressure, random start offset and stray start pulses
        clear_stim();
        t0 = int'($urandom_range(0, 5));
        for (int i = 0; i < MAXC; i++) rdy_a[i] = ($urandom_range(0, 3) != 0);
        st_a[t0] = 1'b1;
        for (int i = 0; i < 8; i++) st_a[t0 + 1 + int'($urandom_range(0, 1499))] = 1'b1;
        do_reset();
        model_fill(4, t0);
        run_until(exp_done + 3);
        chk("rnd_count", 32'(acc4.size()), 32'd256);
        cmp_writes("rnd", acc4);
        chk("rnd_done_count", 32'(done4_q.size()), 32'd1);
        if (done4_q.size() > 0) chk("rnd_done_cyc", 32'(done4_q[0].cyc), 32'(exp_done));

        // Reset while 0x80 stalls in WRITE
        clear_stim();
        st_a[0] = 1'b1; st_a[800] = 1'b1;
        rdy_a[774] = 1'b0; rdy_a[775] = 1'b0;
        rs_a[775] = 1'b1;
        do_reset();
        run_until(775);
        chk("pre_rst_we", 32'(we4), 32'd1);
        chk("pre_rst_addr", 32'(addr4), 32'h80);
        run_until(776);
        chk("mrst_we", 32'(we4), 32'd0);
        chk("mrst_busy", 32'(busy4), 32'd0);
        chk("mrst_done", 32'(done4), 32'd0);
        chk("mrst_addr", 32'(addr4), 32'd0);
        run_until(796);
        cnt = 0;
        foreach (pres4[i]) if (pres4[i].cyc >= 776) cnt++;
        chk("mrst_idle_writes", 32'(cnt), 32'd0);
        chk("mrst_acc_count", 32'(acc4.size()), 32'd128);
        chk("mrst_no_done", 32'(done4_q.size()), 32'd0);
        run_until(807);
        chk("mrst_restart_count", 32'(acc4.size()), 32'd129);
        if (acc4.size() == 129) begin
            chk("mrst_restart_addr", acc4[128].addr, 32'd0);
            chk("mrst_restart_cyc", 32'(acc4[128].cyc), 32'd806);
        end

        // W=3 instance
        clear_stim();
        sel3 = 1'b1;
        st_a[0] = 1'b1;
        do_reset();
        model_fill(3, 0);
        run_until(330);
        chk("w3_count", 32'(acc3.size()), 32'd64);
        cmp_writes("w3", acc3);
        if (acc3.size() == 64) chk("w3_3F_data", acc3[63].data, 32'h31);
        chk("w3_done_count", 32'(done3_q.size()), 32'd1);
        if (done3_q.size() > 0) chk("w3_done_cyc", 32'(done3_q[0].cyc), 32'd321);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
